bcd2bin_seq: RTL and testbench

//  Sequential BCD-to-binary converter; inverse of the bin2bcd_16 display path.

---
 rtl/bcd2bin_seq_pkg.sv | 14 +
 rtl/bcd_mac10.sv | 10 +
 rtl/bcd2bin_seq.sv | 95 +++++++++
 tb/tb_bcd2bin_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd2bin_seq_pkg.sv
// bcd2bin_seq_pkg: shared BCD constants, FSM state encodings and digit helper
// used by the sequential BCD-to-binary converter.
package bcd2bin_seq_pkg;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
        return d > BCD_MAX;
    endfunction
endpackage

// File: rtl/bcd_mac10.sv
// bcd_mac10: combinational acc*10 + digit, built from two shifts and adds.
module bcd_mac10 #(
    parameter int ACC_W = 20
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] result
);
    assign result = (acc << 3) + (acc << 1) + ACC_W'(digit);
endmodule

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter, one digit per clock, MS digit
// first, with saturation on overflow and error flag on non-decimal digits.
module bcd2bin_seq
    import bcd2bin_seq_pkg::*;
#(
    parameter int NDIGITS = 5,
    parameter int WIDTH   = 16
) (
    input  logic                       CLOCK_50,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [DIGIT_W*NDIGITS-1:0] bcd_in,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           bin_out,
    output logic                       ovf,
    output logic                       err
);
    localparam int ACC_W = DIGIT_W * NDIGITS;
    localparam int IDX_W = NDIGITS > 1 ? $clog2(NDIGITS) : 1;

    logic [1:0]         state;
    logic [ACC_W-1:0]   bcd_r;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic [IDX_W-1:0]   idx;
    logic [DIGIT_W-1:0] digit;
    logic               bad;
    logic               over;

    assign digit = bcd_r[idx*DIGIT_W +: DIGIT_W];
    assign over  = |(acc >> WIDTH);

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++)
            bad = bad | digit_bad(bcd_r[i*DIGIT_W +: DIGIT_W]);
    end

    bcd_mac10 #(.ACC_W(ACC_W)) u_mac (
        .acc   (acc),
        .digit (digit),
        .result(acc_next)
    );

    // busy is registered so it stays high through the done cycle and can
    // carry straight into the next conversion when start is held.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            acc     <= '0;
            idx     <= '0;
            bcd_r   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        bcd_r <= bcd_in;
                        acc   <= '0;
                        idx   <= IDX_W'(NDIGITS - 1);
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (bad) begin
                        state <= ST_FIN;
                    end else begin
                        acc   <= ACC_W'(digit);
                        idx   <= idx - 1'b1;
                        state <= idx == '0 ? ST_FIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    idx   <= idx - 1'b1;
                    state <= idx == '0 ? ST_FIN : ST_RUN;
                end
                default: begin
                    done    <= 1'b1;
                    err     <= bad;
                    ovf     <= !bad && over;
                    bin_out <= bad ? '0 : over ? '1 : WIDTH'(acc);
                    state   <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: directed self-checking bench for bcd2bin_seq; done_edge is the
// index of the clock edge after start acceptance (E0 = 0) that raised done.
module tb_bcd2bin_seq;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [19:0] bcd_in;
    logic        busy;
    logic        done;
    logic [15:0] bin_out;
    logic        ovf;
    logic        err;
    int          checks;
    int          failures;

    bcd2bin_seq #(.NDIGITS(5), .WIDTH(16)) dut (
        .CLOCK_50(clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .ovf     (ovf),
        .err     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

    // Pulses start for one cycle and waits (bounded) for done; no comparisons here.
    task automatic run_conv(input logic [19:0] bcd, output int done_edge, output int busy_cycles);
        @(negedge clk);
        bcd_in = bcd;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_edge   = -1;
        busy_cycles = 0;
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                done_edge = e;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        #23 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, bin_out, ovf, err} !== 20'h0) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: busy=%b done=%b bin_out=%h ovf=%b err=%b, required all zero",
                         c, busy, done, bin_out, ovf, err);
            end
        end
    endtask

    task automatic test_convert;
        int de, bc;
        run_conv(20'h12345, de, bc);
        checks++;
        if (de !== 6) begin
            failures++;
            $display("FAIL convert_latency: done_edge=%0d, required 6", de);
        end
        checks++;
        if (bc !== 7) begin
            failures++;
            $display("FAIL convert_busy_cycles: got %0d, required 7", bc);
        end
        checks++;
        if ({bin_out, ovf, err} !== {16'd12345, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL convert_value: bin_out=%0d ovf=%b err=%b, required 12345 0 0", bin_out, ovf, err);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00 || bin_out !== 16'd12345) begin
            failures++;
            $display("FAIL convert_after: done=%b busy=%b bin_out=%0d, required 0 0 12345", done, busy, bin_out);
        end
    endtask

    task automatic test_saturation;
        logic [19:0] vin [3];
        logic [15:0] vout [3];
        logic        vovf [3];
        int          de, bc;
        vin = '{20'h65535, 20'h65536, 20'h99999};
        vout = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
        vovf = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            run_conv(vin[k], de, bc);
            checks++;
            if (de !== 6 || bin_out !== vout[k] || ovf !== vovf[k] || err !== 1'b0) begin
                failures++;
                $display("FAIL saturation %h: done_edge=%0d bin_out=%h ovf=%b err=%b, required 6 %h %b 0",
                         vin[k], de, bin_out, ovf, err, vout[k], vovf[k]);
            end
        end
    endtask

    task automatic test_error;
        int de, bc;
        run_conv(20'h1A345, de, bc);
        checks++;
        if (de !== 2) begin
            failures++;
            $display("FAIL error_latency: done_edge=%0d, required 2", de);
        end
        checks++;
        if (bc !== 3) begin
            failures++;
            $display("FAIL error_busy_cycles: got %0d, required 3", bc);
        end
        checks++;
        if ({bin_out, ovf, err} !== {16'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL error_value: bin_out=%h ovf=%b err=%b, required 0000 0 1", bin_out, ovf, err);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL error_hold: done=%b err=%b, required 0 1", done, err);
        end
    endtask

    task automatic test_back_to_back;
        int          edges [2];
        logic [15:0] vals [2];
        logic        errs [2];
        int          n;
        logic        busy_gap;
        n = 0;
        busy_gap = 1'b0;
        edges = '{-1, -1};
        vals = '{16'hxxxx, 16'hxxxx};
        errs = '{1'bx, 1'bx};
        @(negedge clk);
        bcd_in = 20'h00000;
        start  = 1'b1;
        @(posedge clk);
        #1 bcd_in = 20'h00042;
        for (int e = 0; e < 40 && n < 2; e++) begin
            @(negedge clk);
            if (!busy) busy_gap = 1'b1;
            if (done) begin
                edges[n] = e;
                vals[n]  = bin_out;
                errs[n]  = err;
                n++;
                if (n == 2) start = 1'b0;
            end
        end
        checks++;
        if (edges[0] !== 6 || edges[1] !== 13) begin
            failures++;
            $display("FAIL b2b_edges: done at %0d and %0d, required 6 and 13", edges[0], edges[1]);
        end
        checks++;
        if (vals[0] !== 16'd0 || vals[1] !== 16'd42) begin
            failures++;
            $display("FAIL b2b_values: %0d then %0d, required 0 then 42", vals[0], vals[1]);
        end
        checks++;
        if (errs[0] !== 1'b0 || errs[1] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_err: %b then %b, required 0 then 0", errs[0], errs[1]);
        end
        checks++;
        if (busy_gap !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy: busy dropped=%b, required 0", busy_gap);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int   de, bc;
        logic saw_done;
        saw_done = 1'b0;
        @(negedge clk);
        bcd_in = 20'h54321;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, bin_out, ovf, err} !== 20'h0) begin
            failures++;
            $display("FAIL reset_mid_async: busy=%b done=%b bin_out=%h ovf=%b err=%b, required all zero",
                     busy, done, bin_out, ovf, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_quiet: done/busy seen=%b, required 0", saw_done);
        end
        run_conv(20'h54321, de, bc);
        checks++;
        if (de !== 6 || bin_out !== 16'd54321 || ovf !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_recover: done_edge=%0d bin_out=%0d ovf=%b err=%b, required 6 54321 0 0",
                     de, bin_out, ovf, err);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_convert();
        test_saturation();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
